// File: rtl/operand_fetch.sv
// operand_fetch: issue stage with scoreboard hazard stall and registered operand capture.
// Optional writeback forwarding is enabled by defining OPERAND_FETCH_BYPASS_EN.
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic              in_wen,
  input  logic [OP_W-1:0]   in_op,
  output logic [4:0]        raddr1,
  output logic [4:0]        raddr2,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic              wb_valid,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [4:0]        out_rd,
  output logic              out_wen,
  output logic [OP_W-1:0]   out_op,
  output logic [7:0]        busy
);
  logic [7:0]        busy_q, busy_d, busy_eff, wb_vec, set_vec;
  logic              out_valid_q, hazard, space, issue;
  logic [DATA_W-1:0] out_a_q, out_b_q, a_d, b_d;
  logic [4:0]        out_rd_q;
  logic              out_wen_q;
  logic [OP_W-1:0]   out_op_q;

  assign raddr1  = in_rs1;
  assign raddr2  = in_rs2;
  assign wb_vec  = wb_valid ? (8'd1 << wb_addr[2:0]) : 8'd0;
  assign set_vec = (issue && in_wen) ? (8'd1 << in_rd[2:0]) : 8'd0;
  // Set is OR-ed after the clear so a same-index issue wins over writeback.
  assign busy_d  = (busy_q & ~wb_vec) | set_vec;
`ifdef OPERAND_FETCH_BYPASS_EN
  assign busy_eff = busy_q & ~wb_vec;
  assign a_d = (wb_valid && wb_addr[2:0] == in_rs1[2:0]) ? wb_data : rdata1;
  assign b_d = (wb_valid && wb_addr[2:0] == in_rs2[2:0]) ? wb_data : rdata2;
`else
  assign busy_eff = busy_q;
  assign a_d = rdata1;
  assign b_d = rdata2;
`endif
  assign hazard   = busy_eff[in_rs1[2:0]] | busy_eff[in_rs2[2:0]] | (in_wen & busy_eff[in_rd[2:0]]);
  assign space    = !out_valid_q || out_ready;
  assign in_ready = space && !hazard;
  assign issue    = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_rd_q    <= '0;
      out_wen_q   <= 1'b0;
      out_op_q    <= '0;
    end else begin
      busy_q <= busy_d;
      if (issue) begin
        out_valid_q <= 1'b1;
        out_a_q     <= a_d;
        out_b_q     <= b_d;
        out_rd_q    <= in_rd;
        out_wen_q   <= in_wen;
        out_op_q    <= in_op;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_rd    = out_rd_q;
  assign out_wen   = out_wen_q;
  assign out_op    = out_op_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed vectors with hand-computed expectations for operand_fetch.
module tb_operand_fetch;
`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        clock = 1'b0, reset = 1'b1;
  logic        in_valid = 1'b0, in_ready, in_wen = 1'b0;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0, raddr1, raddr2, wb_addr = '0, out_rd;
  logic [7:0]  in_op = '0, out_op, busy;
  logic [31:0] rdata1 = '0, rdata2 = '0, wb_data = '0, out_a, out_b;
  logic        wb_valid = 1'b0, out_valid, out_ready = 1'b1, out_wen;
  int          checks = 0, failures = 0;

  operand_fetch dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wen(in_wen), .in_op(in_op),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_rd(out_rd), .out_wen(out_wen), .out_op(out_op), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wen, input logic [7:0] op);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_wen = wen; in_op = op;
  endtask

  initial begin
    step; step;
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_a", out_a, 0);
    chk("rst_op", out_op, 0);
    // basic issue
    instr(1, 1, 2, 0, 0, 8'h05); rdata1 = 32'h11; rdata2 = 32'h22;
    #1;
    chk("basic_ready", in_ready, 1);
    chk("raddr1", raddr1, 1);
    chk("raddr2", raddr2, 2);
    step;
    chk("basic_ovalid", out_valid, 1);
    chk("basic_a", out_a, 32'h11);
    chk("basic_b", out_b, 32'h22);
    chk("basic_op", out_op, 8'h05);
    chk("basic_busy", busy, 0);
    // RAW stall on r3
    instr(1, 0, 0, 3, 1, 8'h01);
    step;
    chk("raw_busy_set", busy, 8'h08);
    chk("raw_out_rd", out_rd, 3);
    chk("raw_out_wen", out_wen, 1);
    instr(1, 3, 0, 6, 1, 8'h02); rdata1 = 32'h33;
    #1;
    chk("raw_stall", in_ready, 0);
    step;
    chk("raw_drain", out_valid, 0);
    wb_valid = 1; wb_addr = 3; wb_data = 32'hABCD;
    #1;
    chk("raw_wb_ready", in_ready, BYP);
    step;
    wb_valid = 0;
    if (!BYP) begin
      chk("raw_busy_clr", busy, 0);
      #1;
      chk("raw_ready_after", in_ready, 1);
      step;
    end
    chk("raw_out_a", out_a, BYP ? 32'hABCD : 32'h33);
    chk("raw_busy6", busy, 8'h40);
    in_valid = 0;
    wb_valid = 1; wb_addr = 6;
    step;
    wb_valid = 0;
    chk("clr6", busy, 0);
    // back-pressure
    instr(1, 1, 2, 0, 0, 8'h7E); rdata1 = 32'h1111; rdata2 = 32'h2222;
    step;
    chk("bp_first_a", out_a, 32'h1111);
    out_ready = 0; in_op = 8'h55; rdata1 = 32'h9999; rdata2 = 32'h8888;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", in_ready, 0);
      step;
      chk("bp_valid", out_valid, 1);
      chk("bp_a", out_a, 32'h1111);
      chk("bp_b", out_b, 32'h2222);
      chk("bp_op", out_op, 8'h7E);
    end
    out_ready = 1;
    #1;
    chk("bp_release", in_ready, 1);
    step;
    chk("bp_next_a", out_a, 32'h9999);
    chk("bp_next_op", out_op, 8'h55);
    in_valid = 0;
    step;
    // aliasing of bits [4:3]
    instr(1, 0, 0, 5, 1, 8'h03);
    step;
    chk("alias_busy", busy, 8'h20);
    instr(1, 0, 13, 0, 0, 8'h04);
    #1;
    chk("alias_stall", in_ready, 0);
    wb_valid = 1; wb_addr = 21;
    #1;
    chk("alias_wb_ready", in_ready, BYP);
    step;
    wb_valid = 0;
    chk("alias_clr", busy, 0);
    #1;
    chk("alias_ready", in_ready, 1);
    in_valid = 0;
    step;
    // WAW and simultaneous set/clear on r4
    instr(1, 0, 0, 4, 1, 8'h06);
    step;
    chk("waw_busy", busy, 8'h10);
    wb_valid = 1; wb_addr = 4;
    #1;
    chk("waw_ready", in_ready, BYP);
    step;
    chk("waw_after", busy, BYP ? 8'h10 : 8'h00);
    if (!BYP) begin
      step;
      chk("setwins", busy, 8'h10);
    end
    in_valid = 0;
    step;
    wb_valid = 0;
    chk("r4_clr", busy, 0);
    // fill scoreboard, hold output, then reset
    for (int i = 0; i < 8; i++) begin
      instr(1, 5'(i), 5'(i), 5'(i), 1, 8'h3C);
      step;
    end
    in_valid = 0; out_ready = 0;
    step;
    chk("fill_busy", busy, 8'hFF);
    chk("fill_valid", out_valid, 1);
    reset = 1;
    step;
    reset = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_a", out_a, 0);
    chk("mid_rst_b", out_b, 0);
    chk("mid_rst_rd", out_rd, 0);
    chk("mid_rst_wen", out_wen, 0);
    chk("mid_rst_op", out_op, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue stage directly downstream of the 8-entry register file.
- Takes decoded instruction fields and drives the file's two read addresses.
- Captures both read operands into a pipeline register with a valid/ready handshake.
- Tracks in-flight destination registers in a scoreboard and stalls issue on RAW/WAW hazards until writeback retires them.

Parameters:
- DATA_W, 32, operand/writeback data width (matches register file).
- OP_W, 8, width of opaque opcode/control field passed through.

Ports:
- clock  input  1  clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  stage accepts instruction this cycle.
- in_rs1  input  5  source 1 register number.
- in_rs2  input  5  source 2 register number.
- in_rd  input  5  destination register number.
- in_wen  input  1  instruction will write in_rd.
- in_op  input  OP_W  opcode, passed through.
- raddr1  output  5  to register file raddr1.
- raddr2  output  5  to register file raddr2.
- rdata1  input  DATA_W  from register file rdata1.
- rdata2  input  DATA_W  from register file rdata2.
- wb_valid  input  1  writeback this cycle (same signal as register file write).
- wb_addr  input  5  writeback register number.
- wb_data  input  DATA_W  writeback data.
- out_valid  output  1  operands valid to execute stage.
- out_ready  input  1  execute stage accepts.
- out_a  output  DATA_W  operand 1.
- out_b  output  DATA_W  operand 2.
- out_rd  output  5  destination, registered.
- out_wen  output  1  write flag, registered.
- out_op  output  OP_W  opcode, registered.
- busy  output  8  scoreboard state, for debug and verification.

Behaviour:
- Register index:
  - All register numbers use only bits [2:0]; bits [4:3] are ignored everywhere (hazard compare, scoreboard, bypass).
  - r0 is an ordinary register, not hard-wired.
- Read addresses: raddr1 = in_rs1 and raddr2 = in_rs2, combinational, full 5 bits.
- Scoreboard busy[7:0]:
  - Issue with in_wen=1 sets busy[rd].
  - wb_valid=1 clears busy[wb_addr].
  - Same cycle, same index: the set wins.
  - Writeback to a non-busy register is harmless; busy stays 0.
- Hazard (combinational) = busy_eff[rs1] | busy_eff[rs2] | (in_wen & busy_eff[rd]).
  - Without bypass: busy_eff = busy.
- Handshake:
  - space = !out_valid | out_ready.
  - in_ready = space & !hazard.
  - in_ready does not depend on in_valid.
  - issue = in_valid & in_ready.
- On issue, at the clock edge:
  - out_a <= rdata1 and out_b <= rdata2 (subject to bypass).
  - out_rd, out_wen, out_op <= inputs.
  - out_valid <= 1.
- On out_valid & out_ready without issue: out_valid <= 0; data outputs hold their last value.
- While out_valid & !out_ready: all out_* hold stable. in_ready=0.
- Latency: one cycle from accepted input to out_valid. Throughput: one per cycle when hazard-free and out_ready=1.
- Reset:
  - Takes effect at the next clock edge regardless of activity.
  - busy=0, out_valid=0, out_a=0, out_b=0, out_rd=0, out_wen=0, out_op=0.
  - Any in-flight scoreboard entries are discarded.
- During the reset cycle in_ready is don't-care; no issue is recorded.

Optional Feature:
- Macro: OPERAND_FETCH_BYPASS_EN.
- Defined:
  - busy_eff[i] = busy[i] & !(wb_valid & wb_addr[2:0]==i).
  - On issue, if wb_valid and wb_addr[2:0]==rs1[2:0], out_a <= wb_data instead of rdata1. Same rule for out_b with rs2.
  - The dependent instruction issues in the writeback cycle itself.
- Undefined:
  - busy_eff = busy; no forwarding mux.
  - The dependent instruction issues the cycle after writeback, reading the updated register file.

Test Plan:
- Reset then no activity:
  - in_valid=1, rs1=1, rs2=2, in_wen=0, rdata1=0x11, rdata2=0x22, out_ready=1.
  - Next cycle: out_valid=1, out_a=0x11, out_b=0x22, busy=0x00.
- RAW stall:
  - Issue rd=3 with in_wen=1 → busy=0x08.
  - Next instruction rs1=3 → in_ready=0.
  - wb_valid=1, wb_addr=3, wb_data=0xABCD:
    - Without bypass: in_ready=1 the cycle after, out_a=rdata1.
    - With bypass: in_ready=1 the same cycle, out_a=0xABCD.
- Back-pressure:
  - out_ready=0 with out_valid=1 → in_ready=0; out_a/out_b/out_op hold for 5 cycles.
  - Raise out_ready → the next instruction issues in that cycle.
- Aliasing:
  - busy[5] set via rd=5.
  - Instruction with rs2=13 (0b01101) stalls.
  - wb_addr=21 clears busy[5].
- WAW plus simultaneous set/clear:
  - With bypass, busy[4]=1; wb_valid, wb_addr=4 in the same cycle as issuing rd=4, in_wen=1.
  - Result: busy[4]=1 afterwards.
- Reset mid-operation:
  - busy=0xFF, out_valid=1, out_ready=0.
  - Assert reset one cycle → busy=0, out_valid=0, all out_* = 0.
